// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame sequencer: strips preamble/SFD, delimits frames with SOF/EOF,
// flags ER and length errors, gates admission with EN_i and keeps good/bad counts.
module gmii_rx_frame_ctrl #(
    parameter int MIN_PRE = 2,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        CLK_i,
    input  logic        reset,
    input  logic [7:0]  GMII_RX_RXD_i,
    input  logic        GMII_RX_DV_i,
    input  logic        GMII_RX_ER_i,
    input  logic        EN_i,
    output logic [7:0]  RX_DATA_o,
    output logic        RX_VALID_o,
    output logic        RX_SOF_o,
    output logic        RX_EOF_o,
    output logic        RX_ERR_o,
    output logic [15:0] RX_LEN_o,
    output logic [31:0] GOOD_CNT_o,
    output logic [31:0] BAD_CNT_o,
    output logic        BUSY_o
);

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [3:0]  PCNT_MAX  = 4'd15;
    localparam logic [3:0]  MIN_PRE_L = 4'(MIN_PRE);
    localparam logic [15:0] MIN_LEN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  pcnt;
    logic [15:0] len;
    logic        err;
    logic [7:0]  hold;
    logic        hold_full;
    logic        first;
    logic        rst_tail;

    logic        rxd_pre;
    logic        rxd_sfd;
    logic        pre_ok;
    logic        at_max;
    logic        end_err;

    logic        emit;
    logic        emit_eof;
    logic        emit_err;
    logic [15:0] emit_len;
    logic        inc_good;
    logic        inc_bad;

    assign rxd_pre = (GMII_RX_RXD_i == PRE_BYTE);
    assign rxd_sfd = (GMII_RX_RXD_i == SFD_BYTE);
    assign pre_ok  = (pcnt >= MIN_PRE_L);
    assign at_max  = (len == MAX_LEN_L);
    assign end_err = err | GMII_RX_ER_i | (len < MIN_LEN_L);

    always_ff @(posedge CLK_i or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (GMII_RX_DV_i) begin
                    if (EN_i && rxd_pre) begin
                        state_nxt = ST_PRE;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_PRE: begin
                if (!GMII_RX_DV_i) begin
                    state_nxt = ST_IDLE;
                end else if (rxd_pre) begin
                    state_nxt = ST_PRE;
                end else if (rxd_sfd && pre_ok) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!GMII_RX_DV_i) begin
                    state_nxt = ST_IDLE;
                end else if (at_max) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!GMII_RX_DV_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The last byte is only known when DV falls, so DATA always emits the held byte.
    always_comb begin
        emit     = 1'b0;
        emit_eof = 1'b0;
        emit_err = 1'b0;
        emit_len = '0;
        inc_good = 1'b0;
        inc_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A frame still running when reset releases is dropped without counting.
                if (GMII_RX_DV_i && EN_i && !rxd_pre && !rst_tail) begin
                    inc_bad = 1'b1;
                end
            end
            ST_PRE: begin
                if (!GMII_RX_DV_i || !(rxd_pre || (rxd_sfd && pre_ok))) begin
                    inc_bad = 1'b1;
                end
            end
            ST_DATA: begin
                if (GMII_RX_DV_i) begin
                    emit = hold_full;
                    if (at_max) begin
                        emit_eof = 1'b1;
                        emit_err = 1'b1;
                        emit_len = MAX_LEN_L;
                        inc_bad  = 1'b1;
                    end
                end else if (hold_full) begin
                    emit     = 1'b1;
                    emit_eof = 1'b1;
                    emit_err = end_err;
                    emit_len = len;
                    inc_good = !end_err;
                    inc_bad  = end_err;
                end else begin
                    inc_bad = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_i or posedge reset) begin
        if (reset) begin
            pcnt       <= '0;
            len        <= '0;
            err        <= 1'b0;
            hold       <= '0;
            hold_full  <= 1'b0;
            first      <= 1'b0;
            rst_tail   <= 1'b1;
            RX_DATA_o  <= '0;
            RX_VALID_o <= 1'b0;
            RX_SOF_o   <= 1'b0;
            RX_EOF_o   <= 1'b0;
            RX_ERR_o   <= 1'b0;
            RX_LEN_o   <= '0;
            GOOD_CNT_o <= '0;
            BAD_CNT_o  <= '0;
            BUSY_o     <= 1'b0;
        end else begin
            if (!GMII_RX_DV_i) begin
                rst_tail <= 1'b0;
            end

            case (state)
                ST_IDLE: pcnt <= 4'd1;
                ST_PRE: begin
                    if (rxd_pre && (pcnt != PCNT_MAX)) begin
                        pcnt <= pcnt + 4'd1;
                    end
                    len       <= '0;
                    err       <= 1'b0;
                    hold_full <= 1'b0;
                    first     <= 1'b1;
                end
                ST_DATA: begin
                    if (GMII_RX_DV_i && !at_max) begin
                        hold      <= GMII_RX_RXD_i;
                        hold_full <= 1'b1;
                        len       <= len + 16'd1;
                        err       <= err | GMII_RX_ER_i;
                        if (hold_full) begin
                            first <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            RX_VALID_o <= emit;
            RX_DATA_o  <= emit ? hold : '0;
            RX_SOF_o   <= emit && first;
            RX_EOF_o   <= emit_eof;
            RX_ERR_o   <= emit_err;
            RX_LEN_o   <= emit_len;
            if (inc_good) begin
                GOOD_CNT_o <= GOOD_CNT_o + 32'd1;
            end
            if (inc_bad) begin
                BAD_CNT_o <= BAD_CNT_o + 32'd1;
            end
            BUSY_o <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Directed self-checking bench for gmii_rx_frame_ctrl: framing, errors, length limits,
// enable gating and mid-frame reset.
module tb_gmii_rx_frame_ctrl;

    logic        CLK_i = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  GMII_RX_RXD_i = '0;
    logic        GMII_RX_DV_i = 1'b0;
    logic        GMII_RX_ER_i = 1'b0;
    logic        EN_i = 1'b1;
    logic [7:0]  RX_DATA_o;
    logic        RX_VALID_o;
    logic        RX_SOF_o;
    logic        RX_EOF_o;
    logic        RX_ERR_o;
    logic [15:0] RX_LEN_o;
    logic [31:0] GOOD_CNT_o;
    logic [31:0] BAD_CNT_o;
    logic        BUSY_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int first_cyc = 0;

    logic [7:0]  cap_q[$];
    int          sof_idx_q[$];
    int          sof_cyc_q[$];
    int          eof_idx_q[$];
    logic [15:0] eof_len_q[$];
    logic        eof_err_q[$];
    int          gap_cnt = 0;
    logic        in_frame = 1'b0;

    gmii_rx_frame_ctrl #(
        .MIN_PRE(2),
        .MIN_LEN(64),
        .MAX_LEN(1518)
    ) dut (
        .CLK_i        (CLK_i),
        .reset        (reset),
        .GMII_RX_RXD_i(GMII_RX_RXD_i),
        .GMII_RX_DV_i (GMII_RX_DV_i),
        .GMII_RX_ER_i (GMII_RX_ER_i),
        .EN_i         (EN_i),
        .RX_DATA_o    (RX_DATA_o),
        .RX_VALID_o   (RX_VALID_o),
        .RX_SOF_o     (RX_SOF_o),
        .RX_EOF_o     (RX_EOF_o),
        .RX_ERR_o     (RX_ERR_o),
        .RX_LEN_o     (RX_LEN_o),
        .GOOD_CNT_o   (GOOD_CNT_o),
        .BAD_CNT_o    (BAD_CNT_o),
        .BUSY_o       (BUSY_o)
    );

    always #5 CLK_i = ~CLK_i;

    always @(posedge CLK_i) cyc <= cyc + 1;

    always @(posedge CLK_i) begin
        #1;
        if (RX_VALID_o) begin
            if (RX_SOF_o) begin
                sof_idx_q.push_back(cap_q.size());
                sof_cyc_q.push_back(cyc);
                in_frame = 1'b1;
            end
            cap_q.push_back(RX_DATA_o);
            if (RX_EOF_o) begin
                eof_idx_q.push_back(cap_q.size() - 1);
                eof_len_q.push_back(RX_LEN_o);
                eof_err_q.push_back(RX_ERR_o);
                in_frame = 1'b0;
            end
        end else if (in_frame) begin
            gap_cnt++;
        end
    end

    task automatic clear_mon();
        cap_q.delete();
        sof_idx_q.delete();
        sof_cyc_q.delete();
        eof_idx_q.delete();
        eof_len_q.delete();
        eof_err_q.delete();
        gap_cnt  = 0;
        in_frame = 1'b0;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge CLK_i);
        GMII_RX_DV_i  = dv;
        GMII_RX_ER_i  = er;
        GMII_RX_RXD_i = d;
    endtask

    task automatic send_frame(input int npre, input int nbytes, input int er_idx, input int en_drop_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < nbytes; i++) begin
            drive(1'b1, (i == er_idx), 8'(i));
            if (i == 0) first_cyc = cyc + 1;
            if (i == en_drop_idx) EN_i = 1'b0;
        end
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_i);
        checks++;
        if ({RX_VALID_o, RX_SOF_o, RX_EOF_o, RX_ERR_o, BUSY_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {RX_VALID_o, RX_SOF_o, RX_EOF_o, RX_ERR_o, BUSY_o});
        end
        checks++;
        if ({RX_DATA_o, RX_LEN_o} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data_len: got %h expected 000000", {RX_DATA_o, RX_LEN_o});
        end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_counters: got %h expected 0", {GOOD_CNT_o, BAD_CNT_o});
        end
        reset = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (BUSY_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b expected 0", BUSY_o);
        end
    endtask

    task automatic test_good_frame();
        int nbad;
        int sof_at;
        int eof_at;
        logic [15:0] eof_len;
        logic eof_err;
        clear_mon();
        send_frame(7, 64, -1, -1);
        exp_good++;
        nbad = 0;
        for (int k = 0; k < cap_q.size(); k++) if (cap_q[k] !== 8'(k)) nbad++;
        sof_at  = (sof_idx_q.size() == 1) ? sof_idx_q[0] : -1;
        eof_at  = (eof_idx_q.size() == 1) ? eof_idx_q[0] : -1;
        eof_len = (eof_len_q.size() == 1) ? eof_len_q[0] : 16'hFFFF;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if (cap_q.size() !== 64) begin failures++; $display("FAIL good_bytes: got %0d expected 64", cap_q.size()); end
        checks++;
        if (nbad !== 0) begin failures++; $display("FAIL good_data: got %0d wrong bytes expected 0", nbad); end
        checks++;
        if (sof_at !== 0) begin failures++; $display("FAIL good_sof: got index %0d expected 0", sof_at); end
        checks++;
        if (eof_at !== 63) begin failures++; $display("FAIL good_eof: got index %0d expected 63", eof_at); end
        checks++;
        if ({eof_err, eof_len} !== {1'b0, 16'd64}) begin
            failures++; $display("FAIL good_err_len: got err=%b len=%0d expected err=0 len=64", eof_err, eof_len);
        end
        checks++;
        if ((sof_cyc_q.size() == 1 ? sof_cyc_q[0] - first_cyc : -1) !== 1) begin
            failures++; $display("FAIL good_latency: got first-byte latency mismatch expected 1 edge");
        end
        checks++;
        if (gap_cnt !== 0) begin failures++; $display("FAIL good_gaps: got %0d expected 0", gap_cnt); end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== {32'(exp_good), 32'(exp_bad)}) begin
            failures++; $display("FAIL good_counts: got good=%0d bad=%0d expected good=%0d bad=%0d", GOOD_CNT_o, BAD_CNT_o, exp_good, exp_bad);
        end
    endtask

    task automatic test_er_frame();
        int nbad;
        logic eof_err;
        clear_mon();
        send_frame(7, 64, 10, -1);
        exp_bad++;
        nbad = 0;
        for (int k = 0; k < cap_q.size(); k++) if (cap_q[k] !== 8'(k)) nbad++;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if ({cap_q.size(), nbad} !== {32'd64, 32'd0}) begin
            failures++; $display("FAIL er_stream: got %0d bytes %0d wrong expected 64 bytes 0 wrong", cap_q.size(), nbad);
        end
        checks++;
        if (eof_err !== 1'b1) begin failures++; $display("FAIL er_eof_err: got %b expected 1", eof_err); end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== {32'(exp_good), 32'(exp_bad)}) begin
            failures++; $display("FAIL er_counts: got good=%0d bad=%0d expected good=%0d bad=%0d", GOOD_CNT_o, BAD_CNT_o, exp_good, exp_bad);
        end
    endtask

    task automatic test_short_preamble();
        logic eof_err;
        clear_mon();
        send_frame(1, 10, -1, -1);
        exp_bad++;
        checks++;
        if (cap_q.size() !== 0) begin failures++; $display("FAIL short_pre_bytes: got %0d expected 0", cap_q.size()); end
        checks++;
        if (BAD_CNT_o !== 32'(exp_bad)) begin failures++; $display("FAIL short_pre_bad: got %0d expected %0d", BAD_CNT_o, exp_bad); end
        clear_mon();
        send_frame(2, 64, -1, -1);
        exp_good++;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if ({cap_q.size(), 31'd0, eof_err} !== {32'd64, 32'd0}) begin
            failures++; $display("FAIL min_pre_frame: got %0d bytes err=%b expected 64 bytes err=0", cap_q.size(), eof_err);
        end
        checks++;
        if (GOOD_CNT_o !== 32'(exp_good)) begin failures++; $display("FAIL min_pre_good: got %0d expected %0d", GOOD_CNT_o, exp_good); end
    endtask

    task automatic test_long_frame();
        int nbad;
        int eof_at;
        logic [15:0] eof_len;
        logic eof_err;
        clear_mon();
        send_frame(7, 1600, -1, -1);
        exp_bad++;
        nbad = 0;
        for (int k = 0; k < cap_q.size(); k++) if (cap_q[k] !== 8'(k)) nbad++;
        eof_at  = (eof_idx_q.size() == 1) ? eof_idx_q[0] : -1;
        eof_len = (eof_len_q.size() == 1) ? eof_len_q[0] : 16'hFFFF;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if ({cap_q.size(), nbad} !== {32'd1518, 32'd0}) begin
            failures++; $display("FAIL trunc_stream: got %0d bytes %0d wrong expected 1518 bytes 0 wrong", cap_q.size(), nbad);
        end
        checks++;
        if (eof_at !== 1517) begin failures++; $display("FAIL trunc_eof: got index %0d expected 1517", eof_at); end
        checks++;
        if ({eof_err, eof_len} !== {1'b1, 16'd1518}) begin
            failures++; $display("FAIL trunc_err_len: got err=%b len=%0d expected err=1 len=1518", eof_err, eof_len);
        end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== {32'(exp_good), 32'(exp_bad)}) begin
            failures++; $display("FAIL trunc_counts: got good=%0d bad=%0d expected good=%0d bad=%0d", GOOD_CNT_o, BAD_CNT_o, exp_good, exp_bad);
        end
        clear_mon();
        send_frame(7, 1518, -1, -1);
        exp_good++;
        eof_len = (eof_len_q.size() == 1) ? eof_len_q[0] : 16'hFFFF;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if ({eof_err, eof_len} !== {1'b0, 16'd1518}) begin
            failures++; $display("FAIL max_len_frame: got err=%b len=%0d expected err=0 len=1518", eof_err, eof_len);
        end
        checks++;
        if (GOOD_CNT_o !== 32'(exp_good)) begin failures++; $display("FAIL max_len_good: got %0d expected %0d", GOOD_CNT_o, exp_good); end
    endtask

    task automatic test_runt();
        int sof_at;
        int eof_at;
        logic [15:0] eof_len;
        logic eof_err;
        clear_mon();
        send_frame(7, 20, -1, -1);
        exp_bad++;
        eof_len = (eof_len_q.size() == 1) ? eof_len_q[0] : 16'hFFFF;
        eof_err = (eof_err_q.size() == 1) ? eof_err_q[0] : 1'bx;
        checks++;
        if ({cap_q.size(), 15'd0, eof_err, eof_len} !== {32'd20, 16'd1, 16'd20}) begin
            failures++; $display("FAIL runt_eof: got %0d bytes err=%b len=%0d expected 20 bytes err=1 len=20", cap_q.size(), eof_err, eof_len);
        end
        clear_mon();
        send_frame(7, 1, -1, -1);
        exp_bad++;
        sof_at  = (sof_idx_q.size() == 1) ? sof_idx_q[0] : -1;
        eof_at  = (eof_idx_q.size() == 1) ? eof_idx_q[0] : -1;
        eof_len = (eof_len_q.size() == 1) ? eof_len_q[0] : 16'hFFFF;
        checks++;
        if ({sof_at, eof_at, 16'd0, eof_len} !== {32'd0, 32'd0, 32'd1}) begin
            failures++; $display("FAIL one_byte: got sof=%0d eof=%0d len=%0d expected sof=0 eof=0 len=1", sof_at, eof_at, eof_len);
        end
        clear_mon();
        send_frame(7, 0, -1, -1);
        exp_bad++;
        checks++;
        if (cap_q.size() !== 0) begin failures++; $display("FAIL empty_bytes: got %0d expected 0", cap_q.size()); end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== {32'(exp_good), 32'(exp_bad)}) begin
            failures++; $display("FAIL runt_counts: got good=%0d bad=%0d expected good=%0d bad=%0d", GOOD_CNT_o, BAD_CNT_o, exp_good, exp_bad);
        end
    endtask

    task automatic test_enable();
        clear_mon();
        EN_i = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        checks++;
        if (BUSY_o !== 1'b1) begin failures++; $display("FAIL en_off_busy: got %b expected 1", BUSY_o); end
        send_frame(5, 64, -1, -1);
        checks++;
        if (cap_q.size() !== 0) begin failures++; $display("FAIL en_off_bytes: got %0d expected 0", cap_q.size()); end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o, BUSY_o} !== {32'(exp_good), 32'(exp_bad), 1'b0}) begin
            failures++; $display("FAIL en_off_counts: got good=%0d bad=%0d busy=%b expected good=%0d bad=%0d busy=0", GOOD_CNT_o, BAD_CNT_o, BUSY_o, exp_good, exp_bad);
        end
        clear_mon();
        EN_i = 1'b1;
        send_frame(7, 64, -1, 10);
        exp_good++;
        checks++;
        if ({cap_q.size(), GOOD_CNT_o} !== {32'd64, 32'(exp_good)}) begin
            failures++; $display("FAIL en_mid_drop: got %0d bytes good=%0d expected 64 bytes good=%0d", cap_q.size(), GOOD_CNT_o, exp_good);
        end
        EN_i = 1'b1;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
        reset = 1'b1;
        #1;
        checks++;
        if ({RX_VALID_o, RX_SOF_o, RX_EOF_o, BUSY_o, RX_DATA_o} !== 12'h0) begin
            failures++; $display("FAIL midreset_outputs: got valid=%b data=%h busy=%b expected all 0", RX_VALID_o, RX_DATA_o, BUSY_o);
        end
        checks++;
        if ({GOOD_CNT_o, BAD_CNT_o} !== 64'h0) begin
            failures++; $display("FAIL midreset_counters: got good=%0d bad=%0d expected 0 0", GOOD_CNT_o, BAD_CNT_o);
        end
        exp_good = 0;
        exp_bad  = 0;
        clear_mon();
        for (int i = 20; i < 40; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            if (i == 22) reset = 1'b0;
        end
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        checks++;
        if ({cap_q.size(), GOOD_CNT_o, BAD_CNT_o} !== {32'd0, 32'd0, 32'd0}) begin
            failures++; $display("FAIL midreset_tail: got %0d bytes good=%0d bad=%0d expected 0 0 0", cap_q.size(), GOOD_CNT_o, BAD_CNT_o);
        end
        clear_mon();
        send_frame(7, 64, -1, -1);
        exp_good++;
        checks++;
        if ({cap_q.size(), GOOD_CNT_o, BAD_CNT_o} !== {32'd64, 32'(exp_good), 32'(exp_bad)}) begin
            failures++; $display("FAIL midreset_next: got %0d bytes good=%0d bad=%0d expected 64 1 0", cap_q.size(), GOOD_CNT_o, BAD_CNT_o);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_er_frame();
        test_short_preamble();
        test_long_frame();
        test_runt();
        test_enable();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
